// File: rtl/router_pkt_tx_if.sv
// Host request/payload stream plus router-facing byte bus for router_pkt_tx.
// master = the packet transmitter, slave = host/router side.
interface router_pkt_tx_if;
    logic       start;
    logic [1:0] addr;
    logic [5:0] len;
    logic       inject_err;
    logic [7:0] pl_data;
    logic       pl_valid;
    logic       pl_ready;
    logic       busy;
    logic [7:0] data_out;
    logic       pkt_valid;
    logic       tx_active;
    logic       done;
    logic       start_err;

    modport master (
        input  start, addr, len, inject_err, pl_data, pl_valid, busy,
        output pl_ready, data_out, pkt_valid, tx_active, done, start_err
    );

    modport slave (
        output start, addr, len, inject_err, pl_data, pl_valid, busy,
        input  pl_ready, data_out, pkt_valid, tx_active, done, start_err
    );
endinterface

// File: rtl/router_pkt_tx.sv
// Buffers a whole payload, then sends header/payload/parity to the router input port.
// Latency: len load cycles after start, then one byte per busy=0 edge; busy=1 freezes data_out/pkt_valid.
// Backpressure: pl_ready only while loading; router busy stalls transmission in place.
module router_pkt_tx #(
    parameter int GAP_CYCLES = 2,
    parameter int MAX_LEN    = 63
) (
    input  logic            clk,
    input  logic            rstn,
    router_pkt_tx_if.master io
);

    typedef enum logic [2:0] {
        S_IDLE,
        S_LOAD,
        S_HEADER,
        S_PAYLOAD,
        S_PARITY,
        S_GAP
    } state_t;

    localparam logic [3:0] GAP_LAST = 4'(GAP_CYCLES - 1);

    state_t     state, state_nxt;
    logic [7:0] mem [MAX_LEN];
    logic [5:0] wr_ptr, rd_ptr, len_q;
    logic [1:0] addr_q;
    logic       inj_q;
    logic [7:0] acc;
    logic [3:0] gap_cnt;
    logic [7:0] data_q;
    logic       pv_q, done_q, serr_q;

    logic start_ok, last_wr, pay_last;

    assign start_ok = io.start && (io.addr != 2'd3) && (io.len != 6'd0);
    assign last_wr  = io.pl_valid && (wr_ptr == len_q - 6'd1);
    assign pay_last = (rd_ptr == len_q);

    assign io.pl_ready  = (state == S_LOAD);
    assign io.tx_active = (state != S_IDLE);
    assign io.data_out  = data_q;
    assign io.pkt_valid = pv_q;
    assign io.done      = done_q;
    assign io.start_err = serr_q;

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) state <= S_IDLE;
        else       state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        case (state)
            S_IDLE:    if (start_ok)              state_nxt = S_LOAD;
            S_LOAD:    if (last_wr)               state_nxt = S_HEADER;
            S_HEADER:  if (!io.busy)              state_nxt = S_PAYLOAD;
            S_PAYLOAD: if (!io.busy && pay_last)  state_nxt = S_PARITY;
            S_PARITY:  if (!io.busy)              state_nxt = S_GAP;
            S_GAP:     if (gap_cnt == GAP_LAST)   state_nxt = S_IDLE;
            default:                              state_nxt = S_IDLE;
        endcase
    end

    // Payload storage carries no reset: the pointers alone define what is valid.
    always_ff @(posedge clk) begin
        if (state == S_LOAD && io.pl_valid) mem[wr_ptr] <= io.pl_data;
    end

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            wr_ptr  <= '0;
            rd_ptr  <= '0;
            len_q   <= '0;
            addr_q  <= '0;
            inj_q   <= 1'b0;
            acc     <= '0;
            gap_cnt <= '0;
            data_q  <= '0;
            pv_q    <= 1'b0;
            done_q  <= 1'b0;
            serr_q  <= 1'b0;
        end else begin
            done_q <= 1'b0;
            serr_q <= 1'b0;
            case (state)
                S_IDLE: begin
                    if (start_ok) begin
                        addr_q <= io.addr;
                        len_q  <= io.len;
                        inj_q  <= io.inject_err;
                        acc    <= {io.len, io.addr};
                        wr_ptr <= '0;
                    end else if (io.start) begin
                        serr_q <= 1'b1;
                    end
                end
                S_LOAD: begin
                    if (io.pl_valid) begin
                        wr_ptr <= wr_ptr + 6'd1;
                        acc    <= acc ^ io.pl_data;
                        if (last_wr) begin
                            data_q <= {len_q, addr_q};
                            pv_q   <= 1'b1;
                        end
                    end
                end
                S_HEADER: begin
                    if (!io.busy) begin
                        data_q <= mem[0];
                        rd_ptr <= 6'd1;
                    end
                end
                S_PAYLOAD: begin
                    if (!io.busy) begin
                        if (!pay_last) begin
                            data_q <= mem[rd_ptr];
                            rd_ptr <= rd_ptr + 6'd1;
                        end else begin
                            data_q <= acc ^ {7'b0, inj_q};
                            pv_q   <= 1'b0;
                        end
                    end
                end
                S_PARITY: begin
                    if (!io.busy) begin
                        data_q  <= '0;
                        done_q  <= 1'b1;
                        gap_cnt <= '0;
                    end
                end
                S_GAP: gap_cnt <= gap_cnt + 4'd1;
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_router_pkt_tx.sv
// Directed stimulus for router_pkt_tx; a negedge monitor pops expected bytes from a scoreboard queue.
module tb_router_pkt_tx;

    logic clk = 1'b0;
    logic rstn = 1'b0;
    always #5 clk = ~clk;

    router_pkt_tx_if io ();

    router_pkt_tx #(.GAP_CYCLES(2), .MAX_LEN(63)) dut (
        .clk  (clk),
        .rstn (rstn),
        .io   (io.master)
    );

    int         n_vec = 0;
    int         n_err = 0;
    int         done_cnt = 0;
    int         n_bytes = 0;
    logic [8:0] exp_q [$];
    logic [7:0] pl_q [$];
    int         stall [66];
    bit         mon_en = 1'b1;

    task automatic chk(input string nm, input int act, input int exp);
        n_vec++;
        if (act != exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", nm, act, exp, $time);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Monitor: a byte transfers on each edge whose preceding sample shows busy=0 while
    // the DUT presents header/payload (pkt_valid=1) or the parity byte that follows.
    bit         in_pkt = 1'b0, cur_in = 1'b0, prev_busy = 1'b0, prev_in = 1'b0;
    logic [8:0] prev_bus = '0;
    logic [8:0] e;
    always @(negedge clk) begin
        if (io.done) done_cnt++;
        if (!rstn) begin
            in_pkt = 1'b0; prev_busy = 1'b0; prev_in = 1'b0;
        end else if (mon_en) begin
            cur_in = io.pkt_valid || in_pkt;
            if (prev_busy && prev_in) chk("hold_during_busy", {io.pkt_valid, io.data_out}, prev_bus);
            prev_busy = io.busy;
            prev_in   = cur_in;
            prev_bus  = {io.pkt_valid, io.data_out};
            if (io.pkt_valid) in_pkt = 1'b1;
            if (cur_in && !io.busy) begin
                n_bytes++;
                if (exp_q.size() == 0) begin
                    n_vec++; n_err++;
                    $display("FAIL xfer: got byte 0x%0h pv=%0b, expected no byte", io.data_out, io.pkt_valid);
                end else begin
                    e = exp_q.pop_front();
                    chk("xfer", {io.pkt_valid, io.data_out}, e);
                end
                if (!io.pkt_valid) in_pkt = 1'b0;
            end
        end
    end

    // Sends one packet from pl_q; exp_par < 0 means derive parity by XOR of header+payload.
    task automatic send(input logic [1:0] a, input logic [5:0] l, input bit inj,
                        input bit toggle, input int exp_par);
        logic [7:0] par;
        int d0, b0;
        par = {l, a};
        exp_q.push_back({1'b1, l, a});
        for (int i = 0; i < l; i++) begin
            exp_q.push_back({1'b1, pl_q[i]});
            par ^= pl_q[i];
        end
        if (inj) par[0] = ~par[0];
        if (exp_par >= 0) par = 8'(exp_par);
        exp_q.push_back({1'b0, par});
        d0 = done_cnt; b0 = n_bytes;

        io.start = 1'b1; io.addr = a; io.len = l; io.inject_err = inj;
        step();
        io.start = 1'b0; io.inject_err = 1'b0;
        chk("pl_ready_in_load", io.pl_ready, 1);
        for (int i = 0; i < l; i++) begin
            if (toggle && i > 0) begin
                io.pl_valid = 1'b0;
                step();
            end
            io.pl_valid = 1'b1; io.pl_data = pl_q[i];
            step();
        end
        io.pl_valid = 1'b0;
        chk("pl_ready_after_load", io.pl_ready, 0);
        for (int k = 0; k < l + 2; k++) begin
            io.busy = 1'b1;
            repeat (stall[k]) step();
            io.busy = 1'b0;
            step();
        end
        chk("tx_active_in_gap", io.tx_active, 1);
        step();
        step();
        chk("tx_active_after_gap", io.tx_active, 0);
        chk("done_pulses", done_cnt - d0, 1);
        chk("bytes_out", n_bytes - b0, l + 2);
        chk("scoreboard_drained", exp_q.size(), 0);
        foreach (stall[k]) stall[k] = 0;
        pl_q.delete();
    endtask

    task automatic bad_start(input logic [1:0] a, input logic [5:0] l);
        int d0;
        d0 = done_cnt;
        io.start = 1'b1; io.addr = a; io.len = l;
        step();
        io.start = 1'b0;
        chk("start_err_pulse", io.start_err, 1);
        chk("bad_pl_ready", io.pl_ready, 0);
        chk("bad_tx_active", io.tx_active, 0);
        chk("bad_pkt_valid", io.pkt_valid, 0);
        step();
        chk("start_err_clear", io.start_err, 0);
        chk("bad_still_idle", io.tx_active, 0);
        chk("bad_no_done", done_cnt - d0, 0);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "timeout");
    end

    initial begin
        io.start = 1'b0; io.addr = '0; io.len = '0; io.inject_err = 1'b0;
        io.pl_data = '0; io.pl_valid = 1'b0; io.busy = 1'b0;
        foreach (stall[k]) stall[k] = 0;
        #12;
        chk("rst_data_out", io.data_out, 0);
        chk("rst_pkt_valid", io.pkt_valid, 0);
        chk("rst_pl_ready", io.pl_ready, 0);
        chk("rst_done", io.done, 0);
        chk("rst_start_err", io.start_err, 0);
        chk("rst_tx_active", io.tx_active, 0);
        @(negedge clk) rstn = 1'b1;
        step();

        // Basic packet: header 0x0D, parity 0x0D.
        pl_q = '{8'h11, 8'h22, 8'h33};
        send(2'd1, 6'd3, 1'b0, 1'b0, 8'h0D);

        // Corrupted parity.
        pl_q = '{8'h11, 8'h22, 8'h33};
        send(2'd1, 6'd3, 1'b1, 1'b0, 8'h0C);

        // Stalls: 3 cycles before first payload byte, 2 before the second.
        pl_q = '{8'hA0, 8'hB1, 8'hC2, 8'hD3};
        stall[1] = 3; stall[2] = 2;
        send(2'd2, 6'd4, 1'b0, 1'b0, 8'h12);

        bad_start(2'd3, 6'd5);
        bad_start(2'd1, 6'd0);

        // Maximum length with a gappy host stream.
        for (int i = 0; i < 63; i++) pl_q.push_back(8'((i * 37 + 5) & 8'hFF));
        send(2'd0, 6'd63, 1'b0, 1'b1, -1);

        // Abort mid-payload with reset.
        begin
            int d0;
            d0 = done_cnt;
            mon_en = 1'b0;
            io.start = 1'b1; io.addr = 2'd1; io.len = 6'd8;
            step();
            io.start = 1'b0;
            for (int i = 0; i < 8; i++) begin
                io.pl_valid = 1'b1; io.pl_data = 8'(8'h80 + i);
                step();
            end
            io.pl_valid = 1'b0;
            repeat (5) step();
            chk("abort_byte5_present", {io.pkt_valid, io.data_out}, 9'h184);
            #2 rstn = 1'b0;
            #1;
            chk("async_rst_pkt_valid", io.pkt_valid, 0);
            chk("async_rst_data_out", io.data_out, 0);
            chk("async_rst_tx_active", io.tx_active, 0);
            repeat (2) @(posedge clk);
            @(negedge clk) rstn = 1'b1;
            mon_en = 1'b1;
            step();
            chk("abort_no_done", done_cnt - d0, 0);
        end

        // Fresh packet after abort: header 0x08, parity 0x91.
        pl_q = '{8'h5A, 8'hC3};
        send(2'd0, 6'd2, 1'b0, 1'b0, 8'h91);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
